cpu_core_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle CPU wrapper. It has a fixed 8-bit instruction encoding, a DATA_W-bit datapath, four general registers and a ZNCV condition-code register. Instruction and data memory ports use a req/ready handshake that accepts any number of wait states. The block sits between the instruction/data memories and the top-level SoC, and replaces the single-cycle core.

---
 rtl/cpu_mc_pkg.sv | 46 ++++
 rtl/cpu_mc_alu.sv | 50 +++++
 rtl/cpu_core_mc.sv | 123 ++++++++++++
 tb/tb_cpu_core_mc.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared opcodes, FSM states and flag layout for the multi-cycle core.
package cpu_mc_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_MOV = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_LDR = 4'h6;
   localparam logic [3:0] OP_STR = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_ADC = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // Which CCR bits an opcode is allowed to change; the rest hold.
   function automatic logic [3:0] flag_mask(input logic [3:0] op);
      logic [3:0] m;
      m = 4'b0000;
      case (op)
         OP_ADD, OP_SUB, OP_ADC: m = 4'b1111;
         OP_AND, OP_OR:          m = 4'b0011;
         default:                m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic writes_reg(input logic [3:0] op);
      logic w;
      w = 1'b0;
      case (op)
         OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADC: w = 1'b1;
         default: w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU: result plus Z/N/C/V for the register-register opcodes.
module cpu_mc_alu
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   input  logic              cin,
   output logic [DATA_W-1:0] result,
   output logic              z,
   output logic              n,
   output logic              c,
   output logic              v
);

   localparam int M = DATA_W - 1;

   logic [DATA_W:0] sum;

   always_comb begin
      sum    = '0;
      result = a;
      c      = 1'b0;
      v      = 1'b0;
      case (op)
         OP_MOV: result = b;
         OP_ADD, OP_ADC: begin
            sum    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (op == OP_ADC) & cin};
            result = sum[M:0];
            c      = sum[DATA_W];
            v      = (a[M] == b[M]) && (result[M] != a[M]);
         end
         OP_SUB: begin
            // The zero-extended difference carries out exactly when a < b.
            sum    = {1'b0, a} - {1'b0, b};
            result = sum[M:0];
            c      = sum[DATA_W];
            v      = (a[M] != b[M]) && (result[M] != a[M]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         default: result = a;
      endcase
      z = (result == '0);
      n = result[M];
   end

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle 8-bit-encoding CPU: FETCH/EXEC/MEM/HALT with req/ready memory ports.
module cpu_core_mc
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [7:0]        imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [3:0]        ccr_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted
);

   state_t              state;
   logic [7:0]          ir;
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W-1:0]   regs [4];
   logic [3:0]          ccr;

   logic [3:0]          op;
   logic [1:0]          ra;
   logic [1:0]          rb;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_z, alu_n, alu_c, alu_v;
   logic [3:0]          alu_flags;
   logic [3:0]          mask;

   assign op = ir[7:4];
   assign ra = ir[3:2];
   assign rb = ir[1:0];

   cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (regs[ra]),
      .b      (regs[rb]),
      .op     (op),
      .cin    (ccr[FLAG_C]),
      .result (alu_res),
      .z      (alu_z),
      .n      (alu_n),
      .c      (alu_c),
      .v      (alu_v)
   );

   always_comb begin
      alu_flags         = 4'b0000;
      alu_flags[FLAG_Z] = alu_z;
      alu_flags[FLAG_N] = alu_n;
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
      mask              = flag_mask(op);
   end

   // Requests drop the moment reset is asserted, even mid-transaction.
   assign imem_req  = rst && (state == S_FETCH);
   assign dmem_req  = rst && (state == S_MEM);
   assign imem_addr = pc;
   assign pc_out    = pc;
   assign ccr_out   = ccr;
   assign halted    = (state == S_HALT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_FETCH;
         pc         <= ADDR_W'(RESET_PC);
         ir         <= '0;
         ccr        <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  ir    <= imem_rdata;
                  pc    <= pc + ADDR_W'(1);
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               state <= S_FETCH;
               case (op)
                  OP_LDR, OP_STR: begin
                     // Snapshot the access so it stays stable across wait states.
                     dmem_addr  <= regs[rb][ADDR_W-1:0];
                     dmem_wdata <= regs[ra];
                     dmem_we    <= (op == OP_STR);
                     state      <= S_MEM;
                  end
                  OP_JZ:  if (ccr[FLAG_Z]) pc <= regs[rb][ADDR_W-1:0];
                  OP_JMP: pc <= regs[rb][ADDR_W-1:0];
                  OP_HLT: state <= S_HALT;
                  default: begin
                     if (writes_reg(op)) regs[ra] <= alu_res;
                     ccr <= (ccr & ~mask) | (alu_flags & mask);
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (!dmem_we) regs[ra] <= dmem_rdata;
                  state <= S_FETCH;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: an 8-bit and a 16-bit core share one memory model.
module tb_cpu_core_mc;

   logic clk = 1'b0;
   logic rst8, rst16, sel;

   logic       ireq8, dreq8, dwe8, halted8;
   logic [7:0] iaddr8, daddr8, wdata8, pc8;
   logic [3:0] ccr8;

   logic        ireq16, dreq16, dwe16, halted16;
   logic [7:0]  iaddr16, daddr16, pc16;
   logic [15:0] wdata16;
   logic [3:0]  ccr16;

   logic        iready, dready;
   logic [7:0]  irdata;
   logic [15:0] drdata;

   logic [7:0]  imem [256];
   logic [15:0] dmem [256];
   int i_wait, d_wait, icnt, dcnt, wr_count;
   int checks, errors;

   logic        m_ireq, m_dreq, m_dwe, m_halted;
   logic [7:0]  m_iaddr, m_daddr, m_pc;
   logic [15:0] m_wdata;
   logic [3:0]  m_ccr;

   always #5 clk = ~clk;

   cpu_core_mc #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut8 (
      .clk(clk), .rst(rst8),
      .imem_req(ireq8), .imem_addr(iaddr8), .imem_ready(iready), .imem_rdata(irdata),
      .dmem_req(dreq8), .dmem_we(dwe8), .dmem_addr(daddr8), .dmem_wdata(wdata8),
      .dmem_ready(dready), .dmem_rdata(drdata[7:0]),
      .ccr_out(ccr8), .pc_out(pc8), .halted(halted8)
   );

   cpu_core_mc #(.DATA_W(16), .ADDR_W(8), .RESET_PC(0)) dut16 (
      .clk(clk), .rst(rst16),
      .imem_req(ireq16), .imem_addr(iaddr16), .imem_ready(iready), .imem_rdata(irdata),
      .dmem_req(dreq16), .dmem_we(dwe16), .dmem_addr(daddr16), .dmem_wdata(wdata16),
      .dmem_ready(dready), .dmem_rdata(drdata),
      .ccr_out(ccr16), .pc_out(pc16), .halted(halted16)
   );

   assign m_ireq   = sel ? ireq16   : ireq8;
   assign m_iaddr  = sel ? iaddr16  : iaddr8;
   assign m_dreq   = sel ? dreq16   : dreq8;
   assign m_dwe    = sel ? dwe16    : dwe8;
   assign m_daddr  = sel ? daddr16  : daddr8;
   assign m_wdata  = sel ? wdata16  : {8'h00, wdata8};
   assign m_halted = sel ? halted16 : halted8;
   assign m_pc     = sel ? pc16     : pc8;
   assign m_ccr    = sel ? ccr16    : ccr8;

   assign iready = m_ireq && (icnt >= i_wait);
   assign dready = m_dreq && (dcnt >= d_wait);
   assign irdata = imem[m_iaddr];
   assign drdata = dmem[m_daddr];

   always @(posedge clk) begin
      icnt <= (m_ireq && !iready) ? icnt + 1 : 0;
      dcnt <= (m_dreq && !dready) ? dcnt + 1 : 0;
      if (m_dreq && m_dwe && dready) begin
         dmem[m_daddr] <= m_wdata;
         wr_count      <= wr_count + 1;
      end
   end

   typedef struct {
      logic        w16;
      logic [3:0]  op;
      logic        cin;
      logic [15:0] a, b, res;
      logic [3:0]  ccr;
   } vec_t;

   vec_t vt [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         imem[i] = 8'hF0;
         dmem[i] <= 16'h0000;
      end
   endtask

   task automatic start(input bit w);
      rst8 = 1'b0; rst16 = 1'b0; sel = w;
      wr_count <= 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (w) rst16 = 1'b1; else rst8 = 1'b1;
   endtask

   task automatic wait_halt(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (m_halted) begin ok = 1'b1; break; end
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad, dseen, reqs;
      bit found;
      checks = 0; errors = 0;
      rst8 = 1'b0; rst16 = 1'b0; sel = 1'b0;
      i_wait = 0; d_wait = 0;
      icnt = 0; dcnt = 0; wr_count = 0;
      clear_mem();

      // {w16, op, cin, a, b, result stored, {V,C,N,Z}}
      vt[0]  = '{1'b0, 4'h2, 1'b0, 16'h007F, 16'h0001, 16'h0080, 4'b1010};
      vt[1]  = '{1'b0, 4'h2, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 4'b0101};
      vt[2]  = '{1'b0, 4'h3, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b0001};
      vt[3]  = '{1'b0, 4'h3, 1'b0, 16'h0000, 16'h0001, 16'h00FF, 4'b0110};
      vt[4]  = '{1'b0, 4'h3, 1'b0, 16'h0080, 16'h0001, 16'h007F, 4'b1000};
      vt[5]  = '{1'b0, 4'hA, 1'b1, 16'h0010, 16'h0020, 16'h0031, 4'b0000};
      vt[6]  = '{1'b0, 4'hA, 1'b1, 16'h00FF, 16'h0000, 16'h0000, 4'b0101};
      vt[7]  = '{1'b0, 4'h4, 1'b1, 16'h00F0, 16'h003C, 16'h0030, 4'b0100};
      vt[8]  = '{1'b0, 4'h5, 1'b0, 16'h0080, 16'h0001, 16'h0081, 4'b0010};
      vt[9]  = '{1'b0, 4'h4, 1'b1, 16'h000F, 16'h00F0, 16'h0000, 4'b0101};
      vt[10] = '{1'b0, 4'h1, 1'b1, 16'h0011, 16'h005A, 16'h005A, 4'b0110};
      vt[11] = '{1'b0, 4'hB, 1'b0, 16'h0033, 16'h0044, 16'h0033, 4'b0000};
      vt[12] = '{1'b0, 4'hA, 1'b1, 16'h007F, 16'h0000, 16'h0080, 4'b1010};
      vt[13] = '{1'b1, 4'h2, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
      vt[14] = '{1'b1, 4'h2, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
      vt[15] = '{1'b1, 4'h3, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110};

      // Reset state and first fetch timing.
      imem[0] = 8'h00; imem[1] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_imem_req", {31'd0, ireq8}, 32'd0);
      check("rst_dmem_req", {31'd0, dreq8}, 32'd0);
      check("rst_pc", {24'd0, pc8}, 32'd0);
      check("rst_ccr", {28'd0, ccr8}, 32'd0);
      check("rst_halted", {31'd0, halted8}, 32'd0);
      rst8 = 1'b1;
      #1;
      check("first_req", {31'd0, ireq8}, 32'd1);
      check("first_addr", {24'd0, iaddr8}, 32'd0);
      @(negedge clk);
      check("pc_after_fetch", {24'd0, pc8}, 32'd1);
      check("exec_no_req", {31'd0, ireq8}, 32'd0);
      @(negedge clk);
      check("second_fetch", {23'd0, ireq8, iaddr8}, {23'd0, 1'b1, 8'h01});
      @(negedge clk);
      check("pc_two_instr", {24'd0, pc8}, 32'd2);

      // HLT: halted stays and no requests for 20 cycles.
      wait_halt("hlt_reached", 50);
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ireq8 || dreq8) reqs++;
      end
      check("hlt_no_reqs", reqs, 0);
      check("hlt_stays", {31'd0, halted8}, 32'd1);

      // ALU vectors: load a, b, preset carry, run op, store result to dmem[2].
      for (int k = 0; k < 16; k++) begin
         clear_mem();
         imem[0] = 8'h6C; imem[1] = 8'h67; imem[2] = 8'h2F; imem[3] = 8'h6B;
         imem[4] = vt[k].cin ? 8'h33 : 8'h3C;
         imem[5] = {vt[k].op, 4'b0110};
         imem[6] = 8'h77; imem[7] = 8'hF0;
         dmem[0] <= 16'h0001; dmem[1] <= vt[k].a; dmem[2] <= vt[k].b;
         start(vt[k].w16);
         wait_halt($sformatf("vec%0d_halt", k), 200);
         check($sformatf("vec%0d_res", k), {16'd0, dmem[2]}, {16'd0, vt[k].res});
         check($sformatf("vec%0d_ccr", k), {28'd0, m_ccr}, {28'd0, vt[k].ccr});
      end

      // JZ taken after SUB giving zero, then falls through after 0 - 1.
      for (int t = 0; t < 2; t++) begin
         clear_mem();
         imem[0] = 8'h68; imem[1] = 8'h6E; imem[2] = (t == 0) ? 8'h35 : 8'h36;
         imem[3] = 8'h83; imem[4] = 8'hF0; imem[8'h20] = 8'hF0;
         dmem[0] <= 16'h0001; dmem[1] <= 16'h0020;
         start(1'b0);
         wait_halt($sformatf("jz%0d_halt", t), 200);
         check($sformatf("jz%0d_pc", t), {24'd0, pc8}, (t == 0) ? 32'h21 : 32'h05);
         check($sformatf("jz%0d_ccr", t), {28'd0, ccr8}, (t == 0) ? 32'b0001 : 32'b0110);
      end

      // STR with 3 fetch and 2 data wait states.
      clear_mem();
      imem[0] = 8'h6C; imem[1] = 8'h7F; imem[2] = 8'hF0;
      dmem[0] <= 16'h0005;
      i_wait = 3; d_wait = 2;
      start(1'b0);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ireq8 && iaddr8 == 8'h01) begin found = 1'b1; break; end
      end
      check("ws_str_fetch_seen", {31'd0, found}, 32'd1);
      n = 0; bad = 0; dseen = 0; found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ireq8 && iaddr8 == 8'h02) begin found = 1'b1; break; end
         if (dreq8) begin
            dseen++;
            if (daddr8 !== 8'h05 || wdata8 !== 8'h05 || dwe8 !== 1'b1) bad++;
         end
         if (ireq8 && iaddr8 !== 8'h01) bad++;
      end
      check("ws_next_fetch", {31'd0, found}, 32'd1);
      check("ws_str_cycles", n, 8);
      check("ws_dreq_cycles", dseen, 3);
      check("ws_stable", bad, 0);
      wait_halt("ws_halt", 100);
      check("ws_one_write", wr_count, 1);
      check("ws_data", {16'd0, dmem[5]}, 32'h5);
      i_wait = 0; d_wait = 0;

      // Reset while a STR sits in MEM: nothing written, restart at 0.
      clear_mem();
      imem[0] = 8'h6C; imem[1] = 8'h7F; imem[2] = 8'hF0;
      dmem[0] <= 16'h0009;
      d_wait = 4;
      start(1'b0);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dreq8 && dwe8) begin found = 1'b1; break; end
      end
      check("rm_mem_seen", {31'd0, found}, 32'd1);
      rst8 = 1'b0;
      #1;
      check("rm_dreq_drop", {31'd0, dreq8}, 32'd0);
      @(negedge clk);
      check("rm_pc", {24'd0, pc8}, 32'd0);
      rst8 = 1'b1;
      #1;
      check("rm_refetch", {23'd0, ireq8, iaddr8}, {23'd0, 1'b1, 8'h00});
      check("rm_no_write", wr_count, 0);
      wait_halt("rm_halt", 200);
      check("rm_rerun_write", wr_count, 1);
      check("rm_rerun_data", {16'd0, dmem[9]}, 32'h9);
      d_wait = 0;

      // 16-bit core: jump to 0xFF, HLT there, PC wraps to 0x00.
      clear_mem();
      imem[0] = 8'h6C; imem[1] = 8'h93;
      dmem[0] <= 16'h00FF;
      start(1'b1);
      wait_halt("wrap_halt", 100);
      check("wrap_pc", {24'd0, pc16}, 32'd0);
      check("wrap_ccr", {28'd0, ccr16}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
